// File: rtl/floo_vc_credit_scheduler.sv
// Shares one physical link between NumVirtChannels VCs using per-VC credit counters,
// round-robin arbitration with a wormhole lock, and a registered link output.
module floo_vc_credit_scheduler #(
  parameter int unsigned NumVirtChannels = 2,
  parameter type         flit_t          = logic,
  parameter int unsigned CreditDepth     = 4,
  parameter int unsigned CreditWidth     = $clog2(CreditDepth + 1)
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic  [NumVirtChannels-1:0]                    valid_i,
  output logic  [NumVirtChannels-1:0]                    ready_o,
  input  flit_t [NumVirtChannels-1:0]                    data_i,
  input  logic  [NumVirtChannels-1:0]                    last_i,
  output logic  [NumVirtChannels-1:0]                    valid_o,
  output flit_t                                          data_o,
  input  logic  [NumVirtChannels-1:0]                    credit_i,
  output logic  [NumVirtChannels-1:0][CreditWidth-1:0]   credits_o,
  output logic                                           locked_o,
  output logic  [(NumVirtChannels > 1 ? $clog2(NumVirtChannels) : 1)-1:0] lock_vc_o
);

  localparam int unsigned IdxW = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1;

  typedef enum logic {StUnlocked, StLocked} lock_state_e;

  lock_state_e                r_state;
  logic [IdxW-1:0]            r_ptr;
  logic [IdxW-1:0]            r_lock_vc;
  logic [NumVirtChannels-1:0] r_valid;
  flit_t                      r_data;

  logic [NumVirtChannels-1:0] w_elig;
  logic [NumVirtChannels-1:0] w_grant;
  logic [IdxW-1:0]            w_gidx;
  logic [IdxW-1:0]            w_cand;
  logic                       w_found;
  logic                       w_xfer;
  logic                       w_last;

  // Per-VC credit counter; eligibility only looks at the registered count.
  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
    logic [CreditWidth-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_cnt <= CreditWidth'(CreditDepth);
      end else if (credit_i[v] && !w_grant[v]) begin
        if (r_cnt != CreditWidth'(CreditDepth)) r_cnt <= r_cnt + 1'b1;
      end else if (!credit_i[v] && w_grant[v]) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_elig[v]    = valid_i[v] && (r_cnt != '0);
    assign credits_o[v] = r_cnt;

`ifndef SYNTHESIS
    a_stable_valid_in: assert property (@(posedge clk_i) disable iff (!rst_ni)
      valid_i[v] && !ready_o[v] |=> valid_i[v]);
    a_no_credit_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
      credit_i[v] && !w_grant[v] |-> r_cnt != CreditWidth'(CreditDepth));
`endif
  end

  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_cand  = '0;
    w_found = 1'b0;
    if (r_state == StLocked) begin
      if (w_elig[r_lock_vc]) begin
        w_grant[r_lock_vc] = 1'b1;
        w_gidx             = r_lock_vc;
      end
    end else begin
      // Scan p, p+1, ..., wrapping; first eligible VC wins.
      for (int i = 0; i < int'(NumVirtChannels); i++) begin
        w_cand = IdxW'((int'(r_ptr) + i) % int'(NumVirtChannels));
        if (!w_found && w_elig[w_cand]) begin
          w_found         = 1'b1;
          w_grant[w_cand] = 1'b1;
          w_gidx          = w_cand;
        end
      end
    end
  end

  assign w_xfer  = |w_grant;
  assign w_last  = last_i[w_gidx];
  assign ready_o = rst_ni ? w_grant : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= StUnlocked;
      r_lock_vc <= '0;
      r_ptr     <= '0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_state   <= StUnlocked;
        r_lock_vc <= '0;
        r_ptr     <= (w_gidx == IdxW'(NumVirtChannels - 1)) ? '0 : w_gidx + 1'b1;
      end else begin
        r_state   <= StLocked;
        r_lock_vc <= w_gidx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= w_grant;
      if (w_xfer) r_data <= data_i[w_gidx];
    end
  end

  assign valid_o   = r_valid;
  assign data_o    = r_data;
  assign locked_o  = (r_state == StLocked);
  assign lock_vc_o = r_lock_vc;

`ifndef SYNTHESIS
  a_valid_o_onehot0: assert property (@(posedge clk_i) $onehot0(r_valid));
  a_lock_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_state == StLocked |-> (w_grant & ~(NumVirtChannels'(1) << r_lock_vc)) == '0);
`endif

endmodule

// File: doc/floo_vc_credit_scheduler.md
Name: floo_vc_credit_scheduler

Overview:
Output-side scheduler that shares one physical link between NumVirtChannels virtual channels. It uses credit-based flow control against the downstream input FIFO. Each VC has its own credit counter, and the scheduler grants round-robin among eligible VCs. A wormhole lock keeps a multi-flit packet contiguous on the link, and the flit is registered onto the link with 1-cycle latency. It sits between the per-output VC buffers of a router and the physical link, and replaces ready-based backpressure with credit return.

Parameters:
NumVirtChannels, 2, number of VCs sharing the link (>=1)
flit_t, logic, flit payload type
CreditDepth, 4, downstream FIFO depth per VC; initial and maximum credit count (>=1)
CreditWidth, $clog2(CreditDepth+1), derived; do not override

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
valid_i  in  NumVirtChannels  per-VC flit available
ready_o  out  NumVirtChannels  per-VC flit accepted this cycle (one-hot or zero)
data_i  in  NumVirtChannels x flit_t  per-VC flit
last_i  in  NumVirtChannels  per-VC flit is packet tail
valid_o  out  NumVirtChannels  link valid, one-hot VC tag or zero
data_o  out  flit_t  link flit
credit_i  in  NumVirtChannels  downstream freed one slot of VC v (per-cycle pulse)
credits_o  out  NumVirtChannels x CreditWidth  current credit counts
locked_o  out  1  wormhole lock active
lock_vc_o  out  $clog2(NumVirtChannels) (min 1)  locked VC index

Behaviour:
- All state changes on the rising edge of clk_i. While rst_ni=0 at an edge: credits=CreditDepth, rr pointer=0, lock cleared, valid_o=0, data_o='0. ready_o is forced 0 while rst_ni=0. Reset mid-packet drops the lock; no flit is emitted.
- Eligibility: elig[v] = valid_i[v] && credits[v]!=0. Eligibility uses the registered count only, so a credit_i arriving in cycle t is usable in t+1.
- Unlocked: grant the first elig VC scanning from pointer p upward with wrap (p, p+1, ..., N-1, 0, ..., p-1). If none is eligible, there is no grant.
- Locked on VC L: grant only L, if elig[L]. Otherwise idle (bubble); other VCs are blocked.
- ready_o = grant (combinational, same cycle). Transfer happens when valid_i[g] && ready_o[g].
- Output register: on transfer, next cycle valid_o=onehot(g) and data_o=data_i[g]. Otherwise valid_o=0 and data_o holds its last value.
- Latency: input accept to link valid is 1 cycle. Sustained throughput is 1 flit/cycle while credits are available.
- Lock FSM states:
  - UNLOCKED, on transfer with last_i[g]=0 -> LOCKED(L=g).
  - LOCKED, on transfer with last_i[L]=1 -> UNLOCKED.
  - A single-flit packet (last=1 while UNLOCKED) stays UNLOCKED.
- Pointer: on any transfer with last_i[g]=1, p <= (g+1) mod N. Otherwise p is unchanged.
- Credits, per VC:
  - credit_i[v] with no send on v: +1.
  - Send on v with no credit_i: -1.
  - Both in the same cycle: unchanged.
- Credits never underflow, because a VC with zero credits is never granted.
- Credit overflow (credit_i when count=CreditDepth with no send) is a protocol error. The assertion fires and the counter saturates at CreditDepth.
- locked_o and lock_vc_o are registered lock state. lock_vc_o=0 when unlocked.
- NumVirtChannels=1: no arbitration, pointer is constant 0, lock logic is still present (harmless).
- Assertions:
  - StableValidIn: valid_i[v] && !ready_o[v] |=> valid_i[v].
  - valid_o is onehot0.
  - No credit overflow.
  - While locked, grant is limited to L.

Test Plan:
- Reset, then idle → credits_o={4,4}, valid_o=0, locked_o=0, ready_o=0 for all cycles with valid_i=0.
- VC0 sends 6 single-flit packets back-to-back with no credit_i → 4 flits accepted (cycles 0-3), valid_o=01 in cycles 1-4, ready_o[0]=0 from cycle 4. Pulsing credit_i[0] in cycle 6 → 5th flit accepted in cycle 7.
- Both VCs are valid with single-flit packets and ample credit returns → grants alternate 0,1,0,1. Each VC gets 50% of the link.
- VC1 sends a 3-flit packet (last on the 3rd) while VC0 is also valid → VC1 holds the link for 3 consecutive grants with locked_o=1 and lock_vc_o=1. VC0 is then granted next, and the pointer ends at 0→1 after VC0's tail.
- Lock on VC0 with credits[0]=0 mid-packet while VC1 is eligible → bubbles on the link, no VC1 grant. credit_i[0] then resumes VC0 one cycle later.
- Simultaneous credit_i[0] and send on VC0 at count 2 → count stays 2. Assert rst_ni=0 mid-packet → lock cleared, credits=4, valid_o=0 next cycle.
